receiver: RTL and testbench
===========================

RECEIVER -- requirements
Module: receiver

Interface
REQ-001 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-002 SHALL have port rstn  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port serial_in  input  1  serial line, idle high, one bit per clk cycle.
REQ-004 SHALL have port data_out  output  7  received data word, D0 is the first data bit received.
REQ-005 SHALL have port data_valid  output  1  data_out, parity_err and frame_err hold a received frame.
REQ-006 SHALL have port data_ready  input  1  consumer accepts the frame when data_valid && data_ready at a clk edge.
REQ-007 SHALL have port parity_err  output  1  the held frame failed the even-parity check.
REQ-008 SHALL have port frame_err  output  1  the held frame had a stop bit of 0.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse: a completed frame was dropped.
REQ-010 SHALL have port busy  output  1  the FSM is not in IDLE.

Function
REQ-011 Frame format SHALL be: start bit 0, then D0..D6 LSB first, then parity bit P, then stop bit 1; all bits are one clk cycle long.
REQ-012 The FSM SHALL have the states IDLE, DATA, PARITY and STOP.
REQ-013 In IDLE, a sampled 0 SHALL be taken as the start bit: next state DATA, bit counter cleared; a sampled 1 SHALL keep the FSM in IDLE.
REQ-014 DATA SHALL store the sampled bit at index bit_cnt and increment the counter; after 7 bits (bit_cnt 6) the next state SHALL be PARITY.
REQ-015 PARITY SHALL sample P and compute perr = ^{D6..D0} XOR P, i.e. perr=1 when the ones count over data plus P is odd; next state STOP.
REQ-016 STOP SHALL sample the stop bit and set ferr = ~serial_in; the next state SHALL always be IDLE.
REQ-017 Frame completion SHALL take place at the STOP edge, so a start bit sampled at edge N gives completion at edge N+9.
REQ-018 With a free holding register, completion SHALL load data_out, parity_err and frame_err, and data_valid SHALL rise after edge N+9.
REQ-019 A frame SHALL be delivered even when it has an error; the error flags travel with the frame.
REQ-020 Frames SHALL be accepted back-to-back: a start bit on the cycle directly after the stop bit SHALL be detected, with no dead cycle.
REQ-021 data_valid SHALL stay high, and data_out, parity_err and frame_err SHALL stay stable, until the handshake completes.
REQ-022 On a handshake with no completion in the same cycle, data_valid SHALL clear on the next edge.
REQ-023 When completion and a handshake occur at the same edge, the new frame SHALL load and data_valid SHALL stay high, with no overrun.
REQ-024 When a frame completes while data_valid=1 and data_ready=0, the new frame SHALL be discarded, the held frame kept, and overrun pulsed for one cycle.
REQ-025 Receiver FSM operation SHALL be independent of data_ready; no backpressure is applied to the line.

Reset
REQ-026 While rstn=0: FSM in IDLE, bit_cnt=0, shift register=0, data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; after rstn releases, the first sampled 0 starts a new frame.
REQ-028 Synchronizer flops, when present, SHALL reset to 1 (idle line).

Configuration
REQ-029 Macro RECEIVER_SYNC_2FF_EN SHALL control the input synchronizer.
REQ-030 When RECEIVER_SYNC_2FF_EN is defined, serial_in SHALL pass through a two-flop synchronizer before the FSM, and completion SHALL move to edge N+11 relative to the line start bit.
REQ-031 When RECEIVER_SYNC_2FF_EN is undefined, serial_in SHALL be sampled directly, with the timing of REQ-017.

Structure
REQ-032 Package receiver_pkg SHALL hold the state enumeration, DATA_BITS=7 and FRAME_BITS=10.
REQ-033 The synchronizer SHALL be the sub-module sync_2ff (1-bit, reset value parameter), instantiated only under RECEIVER_SYNC_2FF_EN.
REQ-034 The FSM, datapath and holding register SHALL all reside in receiver.

Verification
REQ-035 Data 7'h55 with P=0 and stop 1, data_ready=1: data_out=7'h55, parity_err=0, frame_err=0, data_valid high for exactly one cycle, rising 9 edges after the start edge.
REQ-036 Data 7'h01 with P=0 (wrong): data_out=7'h01 with parity_err=1; then 7'h01 with P=1: parity_err=0.
REQ-037 Data 7'h7F with P=1 and stop bit 0: frame_err=1 and data_out=7'h7F; a following frame 7'h2A with a valid start SHALL still be received correctly.
REQ-038 Two back-to-back frames 7'h12 then 7'h34 with data_ready=0: 7'h12 is held, overrun pulses once at the second stop edge, and data_out stays 7'h12 until data_ready=1.
REQ-039 rstn pulsed low after the 3rd data bit of 7'h3C: all outputs reset, no data_valid; a next frame 7'h0F SHALL then be received correctly.
REQ-040 With RECEIVER_SYNC_2FF_EN defined, repeating the REQ-035 stimulus SHALL give data_valid 11 edges after the line start bit.

Source files
------------

// File: rtl/receiver_pkg.sv
// Shared types and sizes for the serial frame receiver.
// Frame: start 0, D0..D6 LSB first, even parity bit, stop 1.
package receiver_pkg;

  localparam int DATA_BITS  = 7;
  localparam int FRAME_BITS = 10;
  localparam int CNT_W      = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit.
// Ports: clk, rstn (async low), d in, q out; flops reset to RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/receiver.sv
// Serial frame receiver: 1 start, 7 data, even parity, 1 stop bit,
// one bit per clk, delivered through a one-entry valid/ready holding register.
// Ports: clk, rstn (async low), serial_in, data_ready in;
//   data_out, data_valid, parity_err, frame_err, overrun, busy out.
// Macro RECEIVER_SYNC_2FF_EN inserts a 2-flop synchronizer on serial_in
// (adds two cycles of latency); undefined samples serial_in directly.
module receiver
  import receiver_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 serial_in,
  input  logic                 data_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 line;
  logic                 done;
  logic                 take;

`ifdef RECEIVER_SYNC_2FF_EN
  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (serial_in),
    .q    (line)
  );
`else
  assign line = serial_in;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!line) state_nxt = DATA;
      DATA: begin
        if (bit_cnt == CNT_W'(DATA_BITS - 1))
          state_nxt = PARITY;
      end
      PARITY:  state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == STOP);
  // Holding register can take a new frame if empty or
  // being emptied by a handshake on this same edge.
  assign take = !data_valid || data_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      case (state)
        IDLE: bit_cnt <= '0;
        DATA: begin
          shreg[bit_cnt] <= line;
          bit_cnt        <= bit_cnt + CNT_W'(1);
        end
        PARITY: perr <= (^shreg) ^ line;
        default: ;
      endcase
      if (done && take) begin
        data_out   <= shreg;
        parity_err <= perr;
        frame_err  <= ~line;
        data_valid <= 1'b1;
      end else begin
        if (done) overrun <= 1'b1;
        if (data_valid && data_ready)
          data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Scoreboard bench for receiver: directed frames plus random traffic,
// expected frames queued at completion time and checked by a monitor.
module tb_receiver;
  import receiver_pkg::*;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       serial_in = 1'b1;
  logic       data_ready = 1'b0;
  logic [6:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  receiver dut (
    .clk        (clk),
    .rstn       (rstn),
    .serial_in  (serial_in),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

`ifdef RECEIVER_SYNC_2FF_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    logic [6:0] d;
    logic       pe;
    logic       fe;
  } frame_t;

  typedef struct {
    int     edge_no;
    frame_t f;
  } comp_t;

  frame_t exp_q[$];
  comp_t  cq[$];
  comp_t  cm;
  logic   exp_ovr = 1'b0;
  int     cyc = 0;
  int     errors = 0;
  int     checks = 0;
  int     ovr_seen = 0;
  int     rdy_mode = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       data_ready = 1'b0;
      1:       data_ready = 1'b1;
      default: data_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compares at negedge, then predicts the next edge.
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      chk("rst_valid", 32'(data_valid), 0);
      chk("rst_data", 32'(data_out), 0);
      chk("rst_perr", 32'(parity_err), 0);
      chk("rst_ferr", 32'(frame_err), 0);
      chk("rst_ovr", 32'(overrun), 0);
      chk("rst_busy", 32'(busy), 0);
      exp_q.delete();
      cq.delete();
      exp_ovr = 1'b0;
    end else begin
      chk("valid", 32'(data_valid), 32'(exp_q.size() > 0));
      chk("overrun", 32'(overrun), 32'(exp_ovr));
      if (overrun) ovr_seen++;
      if (exp_q.size() > 0 && data_valid) begin
        chk("data", 32'(data_out), 32'(exp_q[0].d));
        chk("perr", 32'(parity_err), 32'(exp_q[0].pe));
        chk("ferr", 32'(frame_err), 32'(exp_q[0].fe));
      end
      exp_ovr = 1'b0;
      if (exp_q.size() > 0 && data_ready)
        void'(exp_q.pop_front());
      if (cq.size() > 0 && cq[0].edge_no == cyc + 1) begin
        cm = cq.pop_front();
        if (exp_q.size() == 0) exp_q.push_back(cm.f);
        else                   exp_ovr = 1'b1;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      serial_in = 1'b1;
    end
  endtask

  task automatic send(input logic [6:0] d, input logic p,
                      input logic s, input int gap);
    logic [9:0] bits;
    comp_t c;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < FRAME_BITS; i++) begin
      @(posedge clk);
      #1;
      serial_in = bits[i];
      if (i == FRAME_BITS - 1) begin
        c.edge_no = cyc + 1 + LAT;
        c.f.d  = d;
        c.f.pe = 1'(($countones({d, p}) % 2) == 1);
        c.f.fe = ~s;
        cq.push_back(c);
      end
    end
    idle(gap);
  endtask

  function automatic logic evenp(input logic [6:0] d);
    return 1'($countones(d) % 2);
  endfunction

  initial begin
    logic [6:0] rd;
    logic [9:0] pb;
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    idle(2);

    send(7'h55, 1'b0, 1'b1, 3);
    send(7'h01, 1'b0, 1'b1, 2);
    send(7'h01, 1'b1, 1'b1, 2);
    send(7'h7F, 1'b1, 1'b0, 0);
    send(7'h2A, evenp(7'h2A), 1'b1, 3);

    rdy_mode = 0;
    idle(1);
    send(7'h12, evenp(7'h12), 1'b1, 0);
    send(7'h34, evenp(7'h34), 1'b1, 6);
    rdy_mode = 1;
    idle(4);
    chk("ovr_count", 32'(ovr_seen), 1);

    pb = {1'b1, evenp(7'h3C), 7'h3C, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      serial_in = pb[i];
    end
    @(posedge clk);
    #1;
    rstn = 1'b0;
    serial_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    idle(2);
    send(7'h0F, evenp(7'h0F), 1'b1, 3);

    rdy_mode = 2;
    repeat (40) begin
      rd = 7'($urandom);
      send(rd,
           evenp(rd) ^ ($urandom_range(0, 3) == 0),
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 3));
    end
    rdy_mode = 1;
    idle(20);
    chk("drained", 32'(exp_q.size() + cq.size()), 0);
    chk("idle_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
